// File: rtl/divider_serial_p.sv
// Serial-in / serial-out restoring integer divider.
// Operands arrive in IN_W-bit beats; quotient (and remainder) leave as one bit stream.
module divider_serial_p #(
   parameter int DATA_W  = 8,
   parameter int IN_W    = 4,
   parameter int SIGNED  = 0,
   parameter int OUT_REM = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [IN_W-1:0] in_data,
   output logic            out_valid,
   output logic            out_data,
   output logic            out_err
);

   localparam int NB    = DATA_W / IN_W;
   localparam int NBEAT = 2 * NB;
   localparam int NOUT  = (OUT_REM != 0) ? 2 * DATA_W : DATA_W;
   localparam int BW    = $clog2(NBEAT + 1);
   localparam int CW    = $clog2(NOUT + 1);
   localparam int SW    = 2 * DATA_W - IN_W;

   if (DATA_W % IN_W != 0) begin : g_bad_width
      $error("DATA_W must be a multiple of IN_W");
   end

   typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_e;

   state_e              state_q, state_d;
   logic [BW-1:0]       bcnt_q, bcnt_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [SW-1:0]       sbuf_q, sbuf_d;
   logic [DATA_W-1:0]   rem_q, rem_d;
   logic [DATA_W-1:0]   quo_q, quo_d;
   logic [DATA_W-1:0]   dvs_q, dvs_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic                qneg_q, qneg_d;
   logic                rneg_q, rneg_d;
   logic                dz_q, dz_d;
   logic                ovf_q, ovf_d;
   logic                ov_q, ov_d;
   logic                od_q, od_d;
   logic                oe_q, oe_d;

   logic [2*DATA_W-1:0] full;
   logic [DATA_W-1:0]   op_a, op_b;
   logic                an, bn;
   logic [DATA_W:0]     tmp, diff;
   logic [DATA_W-1:0]   qf, rf;
   logic [2*DATA_W-1:0] sel;

   assign full = {sbuf_q, in_data};
   assign op_a = full[2*DATA_W-1:DATA_W];
   assign op_b = full[DATA_W-1:0];
   assign an   = (SIGNED != 0) && op_a[DATA_W-1];
   assign bn   = (SIGNED != 0) && op_b[DATA_W-1];

   // rem < dvs keeps tmp - dvs below 2^DATA_W, so diff's top bit is the borrow
   assign tmp  = {rem_q, quo_q[DATA_W-1]};
   assign diff = tmp - {1'b0, dvs_q};

   assign qf = dz_q  ? '1  :
               ovf_q ? a_q :
               (qneg_q ? -quo_q : quo_q);
   assign rf = dz_q  ? a_q :
               ovf_q ? '0  :
               (rneg_q ? -rem_q : rem_q);
   assign sel = {qf, rf} << cnt_q;

   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      cnt_d   = cnt_q;
      sbuf_d  = sbuf_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      a_d     = a_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;
      ov_d    = 1'b0;
      od_d    = 1'b0;
      oe_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               sbuf_d  = full[SW-1:0];
               bcnt_d  = BW'(1);
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (!in_valid) begin
               bcnt_d  = '0;
               state_d = IDLE;
            end else begin
               sbuf_d = full[SW-1:0];
               bcnt_d = bcnt_q + BW'(1);
               if (bcnt_q == BW'(NBEAT - 1)) begin
                  rem_d   = '0;
                  quo_d   = an ? -op_a : op_a;
                  dvs_d   = bn ? -op_b : op_b;
                  a_d     = op_a;
                  qneg_d  = an ^ bn;
                  rneg_d  = an;
                  dz_d    = (op_b == '0);
                  ovf_d   = (SIGNED != 0) &&
                            (op_a == {1'b1, {(DATA_W-1){1'b0}}}) &&
                            (&op_b);
                  bcnt_d  = '0;
                  cnt_d   = '0;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            rem_d = diff[DATA_W] ? tmp[DATA_W-1:0] : diff[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(DATA_W - 1)) begin
               cnt_d   = '0;
               state_d = OUT;
            end
         end
         OUT: begin
            if (cnt_q == CW'(NOUT)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               ov_d  = 1'b1;
               od_d  = sel[2*DATA_W-1];
               oe_d  = dz_q | ovf_q;
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         bcnt_q  <= '0;
         cnt_q   <= '0;
         sbuf_q  <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         a_q     <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
         ov_q    <= 1'b0;
         od_q    <= 1'b0;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         cnt_q   <= cnt_d;
         sbuf_q  <= sbuf_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         a_q     <= a_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
         oe_q    <= oe_d;
      end
   end

   assign out_valid = ov_q;
   assign out_data  = od_q;
   assign out_err   = oe_q;

endmodule

// File: tb/tb_divider_serial_p.sv
// Bench for divider_serial_p: unsigned, signed and quotient-only
// instances share one input stream and are checked against a reference model.
module tb_divider_serial_p;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] in_data = '0;
   logic [2:0] ov, od, oe;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   divider_serial_p #(.DATA_W(8), .IN_W(4), .SIGNED(0), .OUT_REM(1)) u_uns (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .out_valid(ov[0]), .out_data(od[0]), .out_err(oe[0]));

   divider_serial_p #(.DATA_W(8), .IN_W(4), .SIGNED(1), .OUT_REM(1)) u_sgn (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .out_valid(ov[1]), .out_data(od[1]), .out_err(oe[1]));

   divider_serial_p #(.DATA_W(8), .IN_W(4), .SIGNED(0), .OUT_REM(0)) u_quo (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .out_valid(ov[2]), .out_data(od[2]), .out_err(oe[2]));

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void ref_div(input bit sgn, input logic [7:0] a,
                                   input logic [7:0] b,
                                   output logic [7:0] q,
                                   output logic [7:0] r, output bit e);
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      e  = 1'b0;
      if (b == 8'd0) begin
         q = 8'hFF; r = a; e = 1'b1;
      end else if (!sgn) begin
         q = a / b; r = a % b;
      end else if (sa == -128 && sb == -1) begin
         q = a; r = 8'h00; e = 1'b1;
      end else begin
         q = 8'(sa / sb); r = 8'(sa % sb);
      end
   endfunction

   task automatic send_beats(input logic [7:0] a, input logic [7:0] b,
                             input int n);
      logic [15:0] ab;
      ab = {a, b};
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = ab[15-4*i -: 4];
      end
   endtask

   task automatic frame(input logic [7:0] a, input logic [7:0] b,
                        input bit noise);
      logic [31:0] mask [3];
      logic [15:0] res [3];
      int          ecnt [3];
      bit          stray [3];
      logic [7:0]  q, r;
      bit          e;
      int          nout;
      for (int d = 0; d < 3; d++) begin
         mask[d] = '0; res[d] = '0; ecnt[d] = 0; stray[d] = 1'b0;
      end
      send_beats(a, b, 4);
      for (int k = 0; k < 27; k++) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            if (ov[d] === 1'b1) begin
               mask[d][k] = 1'b1;
               res[d] = {res[d][14:0], od[d]};
               if (oe[d] === 1'b1) ecnt[d]++;
            end else if (od[d] !== 1'b0 || oe[d] !== 1'b0) begin
               stray[d] = 1'b1;
            end
         end
         in_valid = (noise && k < 8) ? 1'($urandom_range(1)) : 1'b0;
         in_data  = 4'($urandom);
      end
      for (int d = 0; d < 3; d++) begin
         ref_div(d == 1, a, b, q, r, e);
         nout = (d == 2) ? 8 : 16;
         check($sformatf("valid%0d %h/%h", d, a, b), 64'(mask[d]),
               64'(((64'd1 << nout) - 1) << 9));
         check($sformatf("result%0d %h/%h", d, a, b), 64'(res[d]),
               (d == 2) ? 64'(q) : 64'({q, r}));
         check($sformatf("err%0d %h/%h", d, a, b), 64'(ecnt[d]),
               e ? 64'(nout) : 64'd0);
         check($sformatf("quiet%0d %h/%h", d, a, b), 64'(stray[d]), 64'd0);
      end
   endtask

   task automatic expect_silence(input string tag, input int cycles);
      logic [2:0] seen;
      seen = '0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         seen |= ov | od | oe;
      end
      check(tag, 64'(seen), 64'd0);
   endtask

   initial begin
      logic [7:0] a, b;
      repeat (3) @(negedge clk);
      check("reset outputs", 64'({ov, od, oe}), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      frame(8'd200, 8'd7, 1'b0);
      frame(8'h5A, 8'h00, 1'b0);
      frame(8'h9C, 8'h07, 1'b0);
      frame(8'h80, 8'hFF, 1'b0);

      send_beats(8'h12, 8'h34, 2);
      @(negedge clk);
      in_valid = 1'b0;
      expect_silence("aborted frame", 30);
      frame(8'd15, 8'd4, 1'b1);

      send_beats(8'd77, 8'd5, 4);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("reset mid calc", 64'({ov, od, oe}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      expect_silence("after reset", 30);
      frame(8'd9, 8'd3, 1'b0);

      for (int n = 0; n < 40; n++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         if (n % 7 == 0) b = 8'h00;
         if (n % 9 == 0) b = 8'hFF;
         if (n % 5 == 0) a = 8'h80;
         if (n % 11 == 3) b = 8'h01;
         frame(a, b, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
